// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-wait freeze
// and a debug drain/halt sequence, with a sticky memory timeout flag and stall counter.
module hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [5:0]  id_op,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_write_reg,
   input  logic        branch_taken,
   input  logic        mem_busy,
   input  logic        halt_req,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        load_use,
   output logic        halted,
   output logic        mem_err,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
   localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  drain_q, drain_d;
   logic [15:0] wait_q, wait_d;
   logic [15:0] stall_q, stall_d;
   logic        err_q, err_d;
   logic        uses_rs, uses_rt, hazard;

   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (id_op)
         6'b000000, 6'b000100, 6'b000101, 6'b101011, 6'b101000: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110,
         6'b000111, 6'b100011, 6'b100000: uses_rs = 1'b1;
         default: ;
      endcase
   end

   assign hazard = id_valid & ex_mem_read & (ex_write_reg != 5'd0) &
                   ((uses_rs & (id_rs == ex_write_reg)) | (uses_rt & (id_rt == ex_write_reg)));

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         RUN: if (halt_req && !mem_busy) begin
            state_d = DRAIN;
            drain_d = 4'd0;
         end
         DRAIN: if (!mem_busy) begin
            if (drain_q == DRAIN_LAST) state_d = HALTED;
            else                       drain_d = drain_q + 4'd1;
         end
         HALTED: if (!halt_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // The wait counter saturates so a stuck memory cannot wrap it back below the timeout.
   always_comb begin
      wait_d = 16'd0;
      if (mem_busy) wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
      err_d = err_q | (mem_busy & (wait_d >= TIMEOUT));
      stall_d = stall_q;
      if ((mem_busy || (state_q == RUN && hazard && !branch_taken)) && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         drain_q <= 4'd0;
         wait_q  <= 16'd0;
         stall_q <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      halted      = 1'b0;
      if (rst) begin
         if (mem_busy && state_q != HALTED) begin
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
         end else begin
            case (state_q)
               RUN: begin
                  ex_mem_en = 1'b1;
                  mem_wb_en = 1'b1;
                  if (branch_taken) begin
                     pc_en    = 1'b1;
                     if_id_en = 1'b1;
                  end else if (hazard) begin
                     if_id_flush = 1'b0;
                  end else begin
                     pc_en       = 1'b1;
                     if_id_en    = 1'b1;
                     if_id_flush = 1'b0;
                     id_ex_flush = 1'b0;
                  end
               end
               DRAIN: begin
                  pc_en     = branch_taken;
                  if_id_en  = 1'b1;
                  ex_mem_en = 1'b1;
                  mem_wb_en = 1'b1;
               end
               default: begin
                  if_id_flush = 1'b0;
                  ex_mem_en   = 1'b1;
                  mem_wb_en   = 1'b1;
                  halted      = 1'b1;
               end
            endcase
         end
      end
   end

   assign load_use  = rst & hazard & (state_q != HALTED);
   assign mem_err   = err_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed output vectors checked each cycle
// between clock edges, with DRAIN_CYCLES=3 and MEM_TIMEOUT=3.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, ex_mem_read, branch_taken, mem_busy, halt_req;
   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, ex_write_reg;
   logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en;
   logic        load_use, halted, mem_err;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, load_use, halted, mem_err}
   localparam logic [8:0] O_RST   = 9'b001100000;
   localparam logic [8:0] O_RUN   = 9'b110011000;
   localparam logic [8:0] O_RUNE  = 9'b110011001;
   localparam logic [8:0] O_LU    = 9'b000111100;
   localparam logic [8:0] O_BRLU  = 9'b111111100;
   localparam logic [8:0] O_FRZ   = 9'b000000000;
   localparam logic [8:0] O_FRZE  = 9'b000000001;
   localparam logic [8:0] O_DRNE  = 9'b011111001;
   localparam logic [8:0] O_DRNBE = 9'b111111001;
   localparam logic [8:0] O_HLTE  = 9'b000111011;

   hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
      .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .halt_req(halt_req),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .load_use(load_use), .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {23'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en,
              load_use, halted, mem_err};
   endfunction

   task automatic idle();
      id_valid = 1'b0; id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
      ex_mem_read = 1'b0; ex_write_reg = 5'd0; branch_taken = 1'b0;
      mem_busy = 1'b0; halt_req = 1'b0;
   endtask

   task automatic lw_vs(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr);
      id_valid = 1'b1; id_op = op; id_rs = rs; id_rt = rt;
      ex_mem_read = 1'b1; ex_write_reg = wr;
   endtask

   // Advance one clock; inputs are then changed 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input logic [8:0] exp);
      #1;
      chk(tag, outs(), {23'd0, exp});
   endtask

   initial begin
      idle();
      rst = 1'b0;
      #12;
      look("reset_outs", O_RST);
      chk("reset_stall", 32'(stall_cnt), 32'd0);
      cyc();
      rst = 1'b1;
      look("first_run", O_RUN);

      // ADD reads rt=$5 while LW to $5 is in EX: exactly one stall cycle
      cyc(); lw_vs(6'b000000, 5'd3, 5'd5, 5'd5);
      look("lu_rt", O_LU);
      cyc(); idle();
      look("lu_after", O_RUN);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      cyc(); lw_vs(6'b000000, 5'd0, 5'd0, 5'd0);
      look("lu_zero_reg", O_RUN);
      cyc(); lw_vs(6'b001111, 5'd5, 5'd5, 5'd5);
      look("lu_lui", O_RUN);
      cyc(); lw_vs(6'b001000, 5'd3, 5'd5, 5'd5);
      look("lu_addi_rt", O_RUN);
      cyc(); lw_vs(6'b101011, 5'd2, 5'd7, 5'd7);
      look("lu_sw_rt", O_LU);
      cyc(); lw_vs(6'b000100, 5'd9, 5'd1, 5'd9);
      id_valid = 1'b0;
      look("lu_not_valid", O_RUN);
      chk("stall_cnt_2", 32'(stall_cnt), 32'd2);

      cyc(); lw_vs(6'b100011, 5'd4, 5'd0, 5'd4); branch_taken = 1'b1;
      look("br_over_lu", O_BRLU);
      cyc(); idle();
      chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

      // five busy cycles, timeout 3: mem_err visible from the 4th
      mem_busy = 1'b1;
      look("frz1", O_FRZ); cyc();
      look("frz2", O_FRZ); cyc();
      look("frz3", O_FRZ); cyc();
      look("frz4", O_FRZE); cyc();
      look("frz5", O_FRZE); cyc();
      mem_busy = 1'b0;
      look("frz_done", O_RUNE);
      chk("frz_stall_cnt", 32'(stall_cnt), 32'd7);

      // halt pulse; drop during drain does not abort; 2 frozen cycles extend it
      halt_req = 1'b1;
      look("halt_req_run", O_RUNE);
      cyc(); halt_req = 1'b0;
      look("drain1", O_DRNE);
      cyc(); mem_busy = 1'b1;
      look("drain_frz1", O_FRZE);
      cyc();
      look("drain_frz2", O_FRZE);
      cyc(); mem_busy = 1'b0;
      look("drain2", O_DRNE);
      cyc(); branch_taken = 1'b1;
      look("drain3_br", O_DRNBE);
      cyc(); idle();
      lw_vs(6'b000000, 5'd6, 5'd6, 5'd6);
      look("halted", O_HLTE);
      cyc(); idle();
      look("resume", O_RUNE);
      chk("halt_stall_cnt", 32'(stall_cnt), 32'd9);

      // reset mid-drain clears everything
      halt_req = 1'b1;
      cyc();
      look("drain_again", O_DRNE);
      #2 rst = 1'b0;
      look("rst_drain", O_RST);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      cyc(); halt_req = 1'b0;
      rst = 1'b1;
      look("post_rst_run", O_RUN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
